// File: rtl/cgra_top.sv
// CGRA top wrapper: decodes a free-running address/data config bus into a flat
// store of tile registers and exposes a sampled JTAG-style readback port.
module cgra_top #(
    parameter int NUM_TILES    = 16,
    parameter int NUM_FEATURES = 4,
    parameter int NUM_REGS     = 4
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [31:0] config_addr_in,
    input  logic [31:0] config_data_in,
    input  logic        tck,
    input  logic        tms,
    input  logic        tdi,
    input  logic        trst_n,
    output logic        tdo
);

    localparam int DEPTH = NUM_TILES * NUM_FEATURES * NUM_REGS;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]      tile;
    logic [7:0]       feature;
    logic [7:0]       reg_sel;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] last_addr;
    logic [31:0]      store [DEPTH];

    assign tile    = config_addr_in[15:0];
    assign feature = config_addr_in[23:16];
    assign reg_sel = config_addr_in[31:24];

    // Address 0 is the idle value of the bus, so it never produces a write.
    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        if (config_addr_in != 32'd0
            && 32'(tile)    < 32'(NUM_TILES)
            && 32'(feature) < 32'(NUM_FEATURES)
            && 32'(reg_sel) < 32'(NUM_REGS)) begin
            wr_en  = 1'b1;
            wr_idx = IDX_W'((32'(tile) * 32'(NUM_FEATURES) + 32'(feature))
                            * 32'(NUM_REGS) + 32'(reg_sel));
        end
    end

    // NOTE: the store must read back 0 after reset, so it is a register array with an explicit clear, not a RAM.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
            last_addr <= '0;
        end else if (wr_en) begin
            store[wr_idx] <= config_data_in;
            last_addr     <= wr_idx;
        end
    end

    logic [1:0]  tck_sync;
    logic [1:0]  tms_sync;
    logic [1:0]  tdi_sync;
    logic [1:0]  trst_sync;
    logic        tck_prev;
    logic        tck_rise;
    logic [31:0] shift_reg;

    assign tck_rise = tck_sync[1] & ~tck_prev;

    // JTAG pins are plain data here; all four share the same sync depth so
    // tms/tdi stay aligned with the detected tck edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            tck_sync  <= '0;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
            tck_prev  <= 1'b0;
            shift_reg <= '0;
            tdo       <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[0], tck};
            tms_sync  <= {tms_sync[0], tms};
            tdi_sync  <= {tdi_sync[0], tdi};
            trst_sync <= {trst_sync[0], trst_n};
            tck_prev  <= tck_sync[1];
            if (!trst_sync[1]) begin
                shift_reg <= '0;
                tdo       <= 1'b0;
            end else if (tck_rise) begin
                if (tms_sync[1]) begin
                    shift_reg <= store[last_addr];
                end else begin
                    tdo       <= shift_reg[0];
                    shift_reg <= {tdi_sync[1], shift_reg[31:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_cgra_top.sv
// Self-checking bench for cgra_top: config writes are read back through the
// JTAG capture/shift path and compared against a queue of expected words.
module tb_cgra_top;

    localparam int CLK_HALF = 5;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [31:0] config_addr_in;
    logic [31:0] config_data_in;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        trst_n;
    logic        tdo;

    always #CLK_HALF clk_in = ~clk_in;

    cgra_top dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .config_addr_in (config_addr_in),
        .config_data_in (config_data_in),
        .tck            (tck),
        .tms            (tms),
        .tdi            (tdi),
        .trst_n         (trst_n),
        .tdo            (tdo)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Every task starts and ends 1 time unit after a rising clock edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        config_addr_in = a;
        config_data_in = d;
        step(1);
        config_addr_in = '0;
        config_data_in = '0;
    endtask

    task automatic pulse(input logic m, input logic d);
        tms = m;
        tdi = d;
        tck = 1'b1;
        step(4);
        tck = 1'b0;
        step(4);
    endtask

    task automatic capture(input logic [31:0] exp);
        exp_q.push_back(exp);
        pulse(1'b1, 1'b0);
    endtask

    task automatic shift_word(input string name, input logic [31:0] din);
        logic [31:0] got;
        logic [31:0] exp;
        for (int i = 0; i < 32; i++) begin
            pulse(1'b0, din[i]);
            got[i] = tdo;
        end
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got 0x%08h expected <nothing queued>", name, got);
        end else begin
            exp = exp_q.pop_front();
            check(name, got, exp);
        end
    endtask

    initial begin
        #(100000 * 2 * CLK_HALF);
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "bench did not terminate in time");
    end

    initial begin
        vec_t        vecs [11];
        logic [31:0] a;
        logic [31:0] d;

        vecs[0]  = '{32'h02010003, 32'hDEADBEEF, 32'hDEADBEEF, "write_t3_f1_r2"};
        vecs[1]  = '{32'h00000010, 32'h12345678, 32'hDEADBEEF, "ignore_tile16"};
        vecs[2]  = '{32'h00000000, 32'h55AA55AA, 32'hDEADBEEF, "ignore_addr0"};
        vecs[3]  = '{32'h04000001, 32'h0BADF00D, 32'hDEADBEEF, "ignore_reg4"};
        vecs[4]  = '{32'h00040001, 32'h0BADF00D, 32'hDEADBEEF, "ignore_feat4"};
        vecs[5]  = '{32'h0000FFFF, 32'h0BADF00D, 32'hDEADBEEF, "ignore_tileffff"};
        vecs[6]  = '{32'h0301000F, 32'hCAFEF00D, 32'hCAFEF00D, "write_t15_f1_r3"};
        vecs[7]  = '{32'h00000001, 32'h00000001, 32'h00000001, "write_t1_f0_r0"};
        vecs[8]  = '{32'h01000000, 32'h80000001, 32'h80000001, "write_t0_f0_r1"};
        vecs[9]  = '{32'h02010003, 32'h00000000, 32'h00000000, "overwrite_zero"};
        vecs[10] = '{32'hFF000000, 32'hFFFFFFFF, 32'h00000000, "ignore_regff"};

        reset_in       = 1'b1;
        config_addr_in = '0;
        config_data_in = '0;
        tck            = 1'b0;
        tms            = 1'b0;
        tdi            = 1'b0;
        trst_n         = 1'b1;

        step(2);
        check("reset_tdo", {31'd0, tdo}, 32'd0);
        reset_in       = 1'b0;
        config_data_in = 32'hFFFFFFFF;
        step(3);
        config_data_in = '0;
        capture(32'h0);
        shift_word("reset_store0", 32'h0);

        for (int i = 0; i < 11; i++) begin
            wr(vecs[i].addr, vecs[i].data);
            capture(vecs[i].exp);
            shift_word(vecs[i].name, 32'h0);
        end

        // trst_n mid-shift clears the shift path but leaves the store alone
        wr(32'h02010003, 32'hDEADBEEF);
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1);
        check("trst_pre_tdo", {31'd0, tdo}, 32'd1);
        trst_n = 1'b0;
        step(4);
        check("trst_tdo", {31'd0, tdo}, 32'd0);
        trst_n = 1'b1;
        step(3);
        exp_q.push_back(32'h0);
        shift_word("trst_cleared", 32'h0);
        capture(32'hDEADBEEF);
        shift_word("trst_recapture", 32'h0);

        // capture lands on the same edge as a write: sees the pre-write state
        exp_q.push_back(32'hDEADBEEF);
        tms = 1'b1;
        tdi = 1'b0;
        tck = 1'b1;
        step(2);
        config_addr_in = 32'h0102000A;
        config_data_in = 32'h600DF00D;
        step(1);
        config_addr_in = '0;
        config_data_in = '0;
        step(1);
        tck = 1'b0;
        step(4);
        shift_word("same_cycle_old", 32'h0);
        capture(32'h600DF00D);
        shift_word("same_cycle_new", 32'h0);

        wr(32'h00000002, 32'h0);
        capture(32'h0);
        shift_word("thru_zero", 32'hA5A5A5A5);
        exp_q.push_back(32'hA5A5A5A5);
        shift_word("thru_pattern", 32'h0);

        // 16 back-to-back writes; the capture is timed to land one edge after write k
        for (int k = 0; k < 16; k++) begin
            for (int c = -1; c < 16; c++) begin
                if (c >= 0) begin
                    a = {8'(c % 4), 8'(c / 4), 16'(15 - c)};
                    d = 32'hB0000000 | (32'(k) << 8) | 32'(c);
                    config_addr_in = a;
                    config_data_in = d;
                end else begin
                    config_addr_in = '0;
                    config_data_in = '0;
                end
                if (c == k - 1) begin
                    tms = 1'b1;
                    tck = 1'b1;
                end
                step(1);
            end
            config_addr_in = '0;
            config_data_in = '0;
            step(4);
            tck = 1'b0;
            step(4);
            exp_q.push_back(32'hB0000000 | (32'(k) << 8) | 32'(k));
            shift_word($sformatf("burst_%0d", k), 32'h0);
        end

        // reset mid-shift; the write presented during reset must be dropped
        wr(32'h0301000F, 32'hCAFEF00D);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        check("midreset_pre_tdo", {31'd0, tdo}, 32'd1);
        reset_in       = 1'b1;
        config_addr_in = 32'h0301000F;
        config_data_in = 32'h11111111;
        step(1);
        check("midreset_tdo", {31'd0, tdo}, 32'd0);
        reset_in       = 1'b0;
        config_addr_in = '0;
        config_data_in = '0;
        step(3);
        exp_q.push_back(32'h0);
        shift_word("midreset_shift", 32'h0);
        capture(32'h0);
        shift_word("midreset_capture", 32'h0);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
